// File: rtl/json_command_parser.sv
// Decodes fixed 28-byte command frames {"T":d,"L":sd.dd,"R":sd.dd}\n from a UART byte stream
// into a trigger bit and two signed hundredths values, flagging bad characters and stalls.
module json_command_parser #(
  parameter int VAL_W          = 11,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             cmd_t,
  output logic [VAL_W-1:0] left_val,
  output logic [VAL_W-1:0] right_val,
  output logic             frame_valid,
  output logic             frame_error,
  output logic [1:0]       error_code,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t      state;
  logic [4:0]  idx;
  logic [CW-1:0] tmr;
  logic        sh_t, neg_l, neg_r;
  logic [9:0]  mag_l, mag_r;

  logic        is_digit, is_sign, byte_ok;
  logic [9:0]  d1, d10, d100;
  logic [VAL_W-1:0] l_ext, r_ext;

  assign is_digit = (rx_data >= "0") && (rx_data <= "9");
  assign is_sign  = (rx_data == "-") || (rx_data == "0");
  assign d1   = {6'd0, rx_data[3:0]};
  assign d10  = d1 * 10'd10;
  assign d100 = d1 * 10'd100;
  assign l_ext = VAL_W'(mag_l);
  assign r_ext = VAL_W'(mag_r);
  assign busy  = (state == RECV);

  // Template check for the byte at the current position (index 0 is handled in HUNT).
  always_comb begin
    byte_ok = 1'b0;
    case (idx)
      5'd1, 5'd3, 5'd7, 5'd9, 5'd17, 5'd19: byte_ok = (rx_data == "\"");
      5'd2:                                 byte_ok = (rx_data == "T");
      5'd4, 5'd10, 5'd20:                   byte_ok = (rx_data == ":");
      5'd5:                                 byte_ok = (rx_data == "0") || (rx_data == "1");
      5'd6, 5'd16:                          byte_ok = (rx_data == ",");
      5'd8:                                 byte_ok = (rx_data == "L");
      5'd18:                                byte_ok = (rx_data == "R");
      5'd11, 5'd21:                         byte_ok = is_sign;
      5'd12, 5'd14, 5'd15,
      5'd22, 5'd24, 5'd25:                  byte_ok = is_digit;
      5'd13, 5'd23:                         byte_ok = (rx_data == ".");
      5'd26:                                byte_ok = (rx_data == "}");
      5'd27:                                byte_ok = (rx_data == 8'h0A);
      default:                              byte_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      idx         <= 5'd0;
      tmr         <= '0;
      sh_t        <= 1'b0;
      neg_l       <= 1'b0;
      neg_r       <= 1'b0;
      mag_l       <= '0;
      mag_r       <= '0;
      cmd_t       <= 1'b0;
      left_val    <= '0;
      right_val   <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      error_code  <= 2'b00;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        HUNT: begin
          tmr <= '0;
          if (rx_valid && rx_data == "{") begin
            state <= RECV;
            idx   <= 5'd1;
          end
        end
        RECV: begin
          if (rx_valid) begin
            tmr <= '0;
            if (byte_ok) begin
              case (idx)
                5'd5:  sh_t  <= rx_data[0];
                5'd11: neg_l <= (rx_data == "-");
                5'd12: mag_l <= d100;
                5'd14: mag_l <= mag_l + d10;
                5'd15: mag_l <= mag_l + d1;
                5'd21: neg_r <= (rx_data == "-");
                5'd22: mag_r <= d100;
                5'd24: mag_r <= mag_r + d10;
                5'd25: mag_r <= mag_r + d1;
                default: ;
              endcase
              if (idx == 5'd27) begin
                cmd_t       <= sh_t;
                left_val    <= neg_l ? -l_ext : l_ext;
                right_val   <= neg_r ? -r_ext : r_ext;
                frame_valid <= 1'b1;
                error_code  <= 2'b00;
                state       <= HUNT;
              end else begin
                idx <= idx + 5'd1;
              end
            end else begin
              frame_error <= 1'b1;
              error_code  <= 2'b01;
              // A stray '{' is taken as the start of a fresh frame.
              if (rx_data == "{") idx <= 5'd1;
              else                state <= HUNT;
            end
          end else if (tmr == CW'(TIMEOUT_CYCLES - 1)) begin
            frame_error <= 1'b1;
            error_code  <= 2'b10;
            state       <= HUNT;
            tmr         <= '0;
          end else begin
            tmr <= tmr + CW'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_json_command_parser.sv
// Directed bench for json_command_parser: framing, value decode, bad-char/resync,
// inter-byte timeout, mid-frame reset and back-to-back frames.
module tb_json_command_parser;

  localparam int VAL_W = 11;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             cmd_t;
  logic [VAL_W-1:0] left_val, right_val;
  logic             frame_valid, frame_error, busy;
  logic [1:0]       error_code;

  int tests = 0;
  int fails = 0;
  int fv_cnt = 0, fe_cnt = 0, both_cnt = 0;

  json_command_parser #(.VAL_W(VAL_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_t(cmd_t), .left_val(left_val), .right_val(right_val),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .error_code(error_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters: sampled at posedge, so each reads the previous cycle's value.
  always @(posedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
    if (frame_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
  end

  string F1 = "{\"T\":1,\"L\":-0.10,\"R\":-0.05}\n";
  string F2 = "{\"T\":0,\"L\":00.00,\"R\":00.00}\n";
  string F3 = "{\"T\":1,\"L\":-0.30,\"R\":-0.15}\n";
  string F4 = "{\"T\":0,\"L\":05.67,\"R\":-9.99}\n";
  string F5 = "{\"T\":1,\"L\":09.99,\"R\":-0.00}\n";

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input string s, input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      send_byte(s[i]);
      if (i != hi) idle(gap);
    end
  endtask

  task automatic check_frame(input string nm, input logic t, input int l, input int r);
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL %s frame_valid got %b want 1", nm, frame_valid); end
    tests++; if (cmd_t !== t) begin fails++; $display("FAIL %s cmd_t got %b want %b", nm, cmd_t, t); end
    tests++; if (left_val !== VAL_W'(l)) begin fails++; $display("FAIL %s left_val got %0d want %0d", nm, $signed(left_val), l); end
    tests++; if (right_val !== VAL_W'(r)) begin fails++; $display("FAIL %s right_val got %0d want %0d", nm, $signed(right_val), r); end
    tests++; if (error_code !== 2'b00) begin fails++; $display("FAIL %s error_code got %b want 00", nm, error_code); end
    tests++; if (frame_error !== 1'b0) begin fails++; $display("FAIL %s frame_error got %b want 0", nm, frame_error); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    tests++; if ({cmd_t, left_val, right_val} !== '0) begin fails++; $display("FAIL reset_vals got %b/%0d/%0d want 0/0/0", cmd_t, left_val, right_val); end
    tests++; if ({frame_valid, frame_error, busy} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {frame_valid, frame_error, busy}); end
    tests++; if (error_code !== 2'b00) begin fails++; $display("FAIL reset_code got %b want 00", error_code); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_one_per_clock;
    int fv0;
    fv0 = fv_cnt;
    send_range(F1, 0, 26, 0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL opc_busy got %b want 1", busy); end
    send_byte(F1[27]);
    check_frame("opc", 1'b1, -10, -5);
    idle(1);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL opc_pulse_width got %b want 0", frame_valid); end
    idle(1);
    tests++; if (fv_cnt - fv0 !== 1) begin fails++; $display("FAIL opc_pulses got %0d want 1", fv_cnt - fv0); end
  endtask

  task automatic test_spaced;
    send_range(F2, 0, 27, 10);
    check_frame("spaced", 1'b0, 0, 0);
    idle(2);
    send_range(F3, 0, 27, 0);
    check_frame("spaced_next", 1'b1, -30, -15);
    idle(2);
  endtask

  task automatic test_bad_char;
    send_range(F1, 0, 27, 0);
    idle(2);
    send_range(F1, 0, 7, 0);
    send_byte("X");
    tests++; if (frame_error !== 1'b1) begin fails++; $display("FAIL bad_err got %b want 1", frame_error); end
    tests++; if (error_code !== 2'b01) begin fails++; $display("FAIL bad_code got %b want 01", error_code); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_busy got %b want 0", busy); end
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL bad_fv got %b want 0", frame_valid); end
    tests++; if (cmd_t !== 1'b1 || left_val !== VAL_W'(-10) || right_val !== VAL_W'(-5)) begin
      fails++; $display("FAIL bad_hold got %b/%0d/%0d want 1/-10/-5", cmd_t, $signed(left_val), $signed(right_val)); end
    idle(1);
    // Remaining bytes of the broken frame contain no '{' and must be dropped.
    send_range(F1, 9, 27, 0);
    idle(1);
    tests++; if (error_code !== 2'b01 || busy !== 1'b0) begin fails++; $display("FAIL bad_tail got code %b busy %b want 01 0", error_code, busy); end
    send_range(F4, 0, 27, 0);
    check_frame("after_bad", 1'b0, 567, -999);
    idle(2);
  endtask

  task automatic test_resync;
    send_range(F4, 0, 13, 0);
    send_byte("{");
    tests++; if (frame_error !== 1'b1 || error_code !== 2'b01) begin fails++; $display("FAIL resync_err got %b code %b want 1 01", frame_error, error_code); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL resync_busy got %b want 1", busy); end
    send_range(F5, 1, 27, 0);
    check_frame("resync", 1'b1, 999, 0);
    idle(2);
  endtask

  task automatic test_timeout;
    int fe0, bad;
    send_range(F3, 0, 11, 0);
    bad = 0;
    for (int k = 1; k < TMO; k++) begin
      idle(1);
      if (frame_error !== 1'b0 || busy !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL tmo_early got %0d early cycles want 0", bad); end
    idle(1);
    tests++; if (frame_error !== 1'b1) begin fails++; $display("FAIL tmo_err got %b want 1", frame_error); end
    tests++; if (error_code !== 2'b10) begin fails++; $display("FAIL tmo_code got %b want 10", error_code); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_busy got %b want 0", busy); end
    idle(2);
    // Byte lands on the last idle cycle before expiry: it must win.
    fe0 = fe_cnt;
    send_range(F3, 0, 11, 0);
    idle(TMO - 1);
    send_range(F3, 12, 27, 0);
    check_frame("tmo_edge", 1'b1, -30, -15);
    idle(2);
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL tmo_edge_err got %0d errors want 0", fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid;
    int fv0, fe0;
    send_range(F1, 0, 19, 0);
    rx_data = F1[20]; rx_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rx_valid = 1'b0;
    tests++; if ({cmd_t, left_val, right_val, error_code} !== '0) begin fails++; $display("FAIL rmid_vals got %b/%0d/%0d/%b want 0", cmd_t, left_val, right_val, error_code); end
    tests++; if ({frame_valid, frame_error, busy} !== 3'b000) begin fails++; $display("FAIL rmid_flags got %b want 000", {frame_valid, frame_error, busy}); end
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_range(F1, 21, 27, 0);
    idle(2);
    tests++; if (fv_cnt != fv0 || fe_cnt != fe0) begin fails++; $display("FAIL rmid_tail got fv %0d fe %0d want 0 0", fv_cnt - fv0, fe_cnt - fe0); end
    send_range(F3, 0, 27, 0);
    check_frame("rmid_next", 1'b1, -30, -15);
    idle(2);
  endtask

  task automatic test_back_to_back;
    int fv0;
    fv0 = fv_cnt;
    send_range(F4, 0, 27, 0);
    check_frame("b2b_a", 1'b0, 567, -999);
    send_range(F1, 0, 27, 0);
    check_frame("b2b_b", 1'b1, -10, -5);
    idle(2);
    tests++; if (fv_cnt - fv0 !== 2) begin fails++; $display("FAIL b2b_pulses got %0d want 2", fv_cnt - fv0); end
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL both_high got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_one_per_clock;
    test_spaced;
    test_bad_char;
    test_resync;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/json_command_parser.md
Name: json_command_parser

Overview:
- Receive-side counterpart of the JSON command serializer: consumes the byte stream from the UART receiver and decodes fixed-format command frames of the form {"T":d,"L":sd.dd,"R":sd.dd}\n (28 bytes).
- Outputs the trigger flag and the signed left/right values in hundredths, with a valid pulse per good frame and an error pulse per rejected frame.
- Sits between the UART RX block and the motor/actuator control logic on the robot-side FPGA.

Parameters:
- VAL_W, 11, width of the signed left/right outputs (range -999..999 needs 11).
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes inside a frame before it is abandoned (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- cmd_t  out  1  decoded T field
- left_val  out  VAL_W  signed L value in hundredths (two's complement)
- right_val  out  VAL_W  signed R value in hundredths
- frame_valid  out  1  one-cycle pulse; outputs just updated from a good frame
- frame_error  out  1  one-cycle pulse; frame rejected
- error_code  out  2  01 = bad character, 10 = inter-byte timeout; held until the next error or good frame (00 after a good frame)
- busy  out  1  high while a frame is partially received

Behaviour:
- Reset, sampled on a rising clk while rst_n=0:
  - cmd_t=0, left_val=0, right_val=0, frame_valid=0, frame_error=0, error_code=00, busy=0.
  - State returns to HUNT; any partial frame is discarded.
- States:
  - HUNT: waiting for '{'.
  - RECV: position index 1..27.
- Template by byte index:
  - 0 '{', 1 '"', 2 'T', 3 '"', 4 ':'
  - 5 T digit: '0' or '1'
  - 6 ',', 7 '"', 8 'L', 9 '"', 10 ':'
  - 11 sign: '-' = negative, '0' = positive
  - 12 digit, 13 '.', 14 digit, 15 digit
  - 16 ',', 17 '"', 18 'R', 19 '"', 20 ':'
  - 21 sign, 22 digit, 23 '.', 24 digit, 25 digit
  - 26 '}', 27 0x0A
- Digits are '0'..'9' only.
- Bytes are processed only on cycles where rx_valid=1. Other cycles change nothing except the timeout counter.
- HUNT:
  - A '{' moves the block to RECV at index 1.
  - Any other byte is silently dropped, with no error.
- RECV, matching byte: advance the index. Value fields accumulate in shadow registers: magnitude = d_units*100 + d_tenths*10 + d_hundredths, negated when sign is '-'.
- RECV, mismatching byte:
  - frame_error pulses the next cycle and error_code becomes 01.
  - Shadow values are discarded; outputs keep their previous values.
  - If the offending byte is '{', go to RECV index 1 (resync). Otherwise go to HUNT.
- Completion: the clock edge that accepts 0x0A at index 27 loads cmd_t, left_val and right_val from the shadow registers. In the following cycle frame_valid=1 with the new values visible; error_code becomes 00. Latency is 1 clock from the final byte.
- "-0.00" decodes to 0; this is not an error.
- Timeout:
  - In RECV, a counter clears on every accepted byte and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES: frame_error pulse, error_code=10, go to HUNT.
  - If rx_valid arrives on the same cycle the counter would expire, the byte wins and the counter clears.
  - The counter is held at 0 in HUNT.
- busy=1 exactly while in RECV.
- frame_valid and frame_error are never high in the same cycle.
- Back-to-back frames with consecutive rx_valid strobes are supported at 1 byte/clock. A '{' arriving in the cycle after the 0x0A starts the next frame.
- rx_valid while rst_n=0 is ignored.

Test Plan:
- Send {"T":1,"L":-0.10,"R":-0.05}\n at one byte per clock → one frame_valid pulse 1 clk after the 0x0A; cmd_t=1, left_val=-10, right_val=-5; error_code=00.
- Send {"T":0,"L":00.00,"R":00.00}\n with bytes spaced 10 clks apart → frame_valid; cmd_t=0, left_val=0, right_val=0. Then send {"T":1,"L":-0.30,"R":-0.15}\n → left_val=-30, right_val=-15.
- Corrupt byte 8 to 'X' after a good frame (1,-10,-5) → frame_error, error_code=01, outputs stay 1/-10/-5, busy=0. Next clean frame is accepted normally.
- Inject '{' at index 14 mid-frame, then a full frame starting from '"' → frame_error with code 01, followed by frame_valid with the new frame's values (resync works).
- With TIMEOUT_CYCLES=16, stop after 12 bytes → frame_error with code 10 exactly 16 clks after the last byte, busy drops. A byte arriving on the 16th idle clk instead → no error.
- Assert rst_n=0 for 1 clk at index 20 of a frame → all outputs 0, busy=0. The remainder of the frame produces neither frame_valid nor frame_error; the next full frame decodes correctly.
